// File: rtl/ebpf_shift_pkg.sv
// Shared definitions for the eBPF shift issuer: op encodings, FSM states and
// the operand conditioning applied before a request is handed to the shifter.
package ebpf_shift_pkg;

  localparam int XLEN         = 64;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    OP_LSH  = 2'd0,
    OP_RSH  = 2'd1,
    OP_ARSH = 2'd2,
    OP_ILL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_DRAIN,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic            left;
    logic            arith;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] shift;
  } sh_cmd_t;

  // ALU32 ops only see the low word; ARSH needs the sign carried into the
  // upper half so the 64-bit shifter shifts ones into bit 31.
  function automatic sh_cmd_t shift_cond(input op_e             op,
                                         input logic            alu32,
                                         input logic [XLEN-1:0] value,
                                         input logic [XLEN-1:0] shift);
    sh_cmd_t c;
    c.left  = (op == OP_LSH);
    c.arith = (op == OP_ARSH);
    if (alu32) begin
      c.shift = {{(XLEN-5){1'b0}}, shift[4:0]};
      c.value = c.arith ? {{(XLEN-32){value[31]}}, value[31:0]}
                        : {{(XLEN-32){1'b0}}, value[31:0]};
    end else begin
      c.shift = {{(XLEN-6){1'b0}}, shift[5:0]};
      c.value = value;
    end
    return c;
  endfunction

endpackage

// File: rtl/shift_issuer.sv
// Initiator for the stb/ack shift unit: accepts one shift request, issues it
// once, waits for ack (or times out) and returns the conditioned result.
module shift_issuer
  import ebpf_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic                  req_alu32,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic [DATA_WIDTH-1:0] req_value,
  input  logic [DATA_WIDTH-1:0] req_shift,
  output logic                  sh_stb,
  output logic                  sh_arith,
  output logic                  sh_left,
  output logic [DATA_WIDTH-1:0] sh_value,
  output logic [DATA_WIDTH-1:0] sh_shift,
  input  logic [DATA_WIDTH-1:0] sh_out,
  input  logic                  sh_ack,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  alu32_q, alu32_d;
  logic                  sh_arith_q, sh_arith_d;
  logic                  sh_left_q, sh_left_d;
  logic [DATA_WIDTH-1:0] sh_value_q, sh_value_d;
  logic [DATA_WIDTH-1:0] sh_shift_q, sh_shift_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q, rsp_tag_d;
  logic                  rsp_err_q, rsp_err_d;
  sh_cmd_t               cmd;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu32_d      = alu32_q;
    sh_arith_d   = sh_arith_q;
    sh_left_d    = sh_left_q;
    sh_value_d   = sh_value_q;
    sh_shift_d   = sh_shift_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    cmd          = shift_cond(op_e'(req_op), req_alu32, req_value, req_shift);

    unique case (state_q)
      ST_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          rsp_tag_d = req_tag;
          alu32_d   = req_alu32;
          if (op_e'(req_op) == OP_ILL) begin
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            state_d      = ST_RESP;
          end else begin
            sh_left_d  = cmd.left;
            sh_arith_d = cmd.arith;
            sh_value_d = cmd.value;
            sh_shift_d = cmd.shift;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sh_ack) begin
          rsp_result_d = alu32_q ? {{(DATA_WIDTH-32){1'b0}}, sh_out[31:0]} : sh_out;
          rsp_err_d    = 1'b0;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO_LIMIT) begin
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_DRAIN;
      cnt_q        <= 8'd0;
      alu32_q      <= 1'b0;
      sh_arith_q   <= 1'b0;
      sh_left_q    <= 1'b0;
      sh_value_q   <= '0;
      sh_shift_q   <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu32_q      <= alu32_d;
      sh_arith_q   <= sh_arith_d;
      sh_left_q    <= sh_left_d;
      sh_value_q   <= sh_value_d;
      sh_shift_q   <= sh_shift_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign sh_stb     = (state_q == ST_ISSUE);
  assign sh_arith   = sh_arith_q;
  assign sh_left    = sh_left_q;
  assign sh_value   = sh_value_q;
  assign sh_shift   = sh_shift_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_shift_issuer.sv
// Bench for shift_issuer: a behavioural stb/ack responder with programmable
// ack delay, directed cases and randomized requests against a reference model.
module tb_shift_issuer;

  localparam int DW  = 64;
  localparam int TW  = 4;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_alu32;
  logic [1:0]    req_op;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] req_value, req_shift;
  logic          sh_stb, sh_arith, sh_left, sh_ack;
  logic [DW-1:0] sh_value, sh_shift, sh_out;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_result;
  logic [TW-1:0] rsp_tag;

  int n_vec = 0;
  int n_bad = 0;

  shift_issuer #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_alu32(req_alu32), .req_tag(req_tag), .req_value(req_value),
    .req_shift(req_shift),
    .sh_stb(sh_stb), .sh_arith(sh_arith), .sh_left(sh_left),
    .sh_value(sh_value), .sh_shift(sh_shift), .sh_out(sh_out), .sh_ack(sh_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural shifter: acks ack_delay cycles after the stb cycle (0 = never)
  int            cyc = 0;
  int            ack_delay = 2;
  int            ack_cycle = -1;
  int            stb_cnt = 0;
  bit            spurious_ack = 1'b0;
  logic [DW-1:0] sh_res;
  logic [DW-1:0] cap_value, cap_shift;
  logic          cap_left, cap_arith;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sh_stb) begin
      stb_cnt++;
      cap_value = sh_value;
      cap_shift = sh_shift;
      cap_left  = sh_left;
      cap_arith = sh_arith;
      if (sh_left)       sh_res = sh_value << sh_shift[5:0];
      else if (sh_arith) sh_res = DW'($signed(sh_value) >>> sh_shift[5:0]);
      else               sh_res = sh_value >> sh_shift[5:0];
      ack_cycle = (ack_delay > 0) ? cyc + ack_delay : -1;
    end
    sh_ack = (cyc == ack_cycle) || spurious_ack;
    sh_out = (cyc == ack_cycle) ? sh_res : {$urandom, $urandom};
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic alu32,
                                             input logic [63:0] v, input logic [63:0] s);
    logic [31:0] r32;
    logic [31:0] v32;
    int unsigned amt;
    if (alu32) begin
      amt = s % 32;
      v32 = v[31:0];
      case (op)
        2'd0:    r32 = v32 << amt;
        2'd1:    r32 = v32 >> amt;
        default: r32 = 32'($signed(v32) >>> amt);
      endcase
      return {32'h0, r32};
    end
    amt = s % 64;
    case (op)
      2'd0:    return v << amt;
      2'd1:    return v >> amt;
      default: return 64'($signed(v) >>> amt);
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"},  64'(req_ready),  64'd0);
    check_val({tag, "_sh_stb"},     64'(sh_stb),     64'd0);
    check_val({tag, "_sh_lr"},      {62'd0, sh_left, sh_arith}, 64'd0);
    check_val({tag, "_sh_value"},   sh_value,        64'd0);
    check_val({tag, "_sh_shift"},   sh_shift,        64'd0);
    check_val({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    check_val({tag, "_rsp_result"}, rsp_result,      64'd0);
    check_val({tag, "_rsp_tag_err"}, {59'd0, rsp_tag, rsp_err}, 64'd0);
  endtask

  // Holds reset for one edge, releases it and times the drain until req_ready.
  task automatic apply_reset(input string tag);
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    spurious_ack = 1'b1;
    @(negedge clk);
    check_reset_outputs(tag);
    rst_n = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) check_val({tag, "_drain_rsp"}, 64'(rsp_valid), 64'd0);
    end
    spurious_ack = 1'b0;
    check_val({tag, "_drain_len"}, 64'(n), 64'(3));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_val({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
  endtask

  // Presents one request at a negedge; returns after the accepting edge.
  task automatic send_req(input logic [1:0] op, input logic alu32, input logic [TW-1:0] tag,
                          input logic [63:0] value, input logic [63:0] shift);
    req_valid = 1'b1;
    req_op    = op;
    req_alu32 = alu32;
    req_tag   = tag;
    req_value = value;
    req_shift = shift;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_alu32 = 1'($urandom);
    req_tag   = TW'($urandom);
    req_value = {$urandom, $urandom};
    req_shift = {$urandom, $urandom};
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic alu32,
                       input logic [63:0] value, input logic [63:0] shift,
                       input int delay, input int hold, input bit late_ack);
    logic [TW-1:0] t;
    logic [63:0]   exp_res, exp_shift, exp_sv, held;
    logic          exp_err;
    int            exp_lat, exp_stb, lat, s0;
    t         = TW'($urandom);
    exp_err   = (op == 2'd3) || (delay == 0) || (delay > TMO);
    exp_lat   = (op == 2'd3) ? 1 : exp_err ? TMO + 2 : delay + 2;
    exp_stb   = (op == 2'd3) ? 0 : 1;
    exp_res   = exp_err ? 64'd0 : ref_result(op, alu32, value, shift);
    exp_shift = alu32 ? (shift % 32) : (shift % 64);
    if (!alu32)          exp_sv = value;
    else if (op == 2'd2) exp_sv = {{32{value[31]}}, value[31:0]};
    else                 exp_sv = {32'h0, value[31:0]};

    ack_delay = delay;
    wait_ready(tag);
    s0 = stb_cnt;
    send_req(op, alu32, t, value, shift);
    lat = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    check_val({tag, "_latency"},   64'(lat),       64'(exp_lat));
    check_val({tag, "_result"},    rsp_result,     exp_res);
    check_val({tag, "_err"},       64'(rsp_err),   64'(exp_err));
    check_val({tag, "_tag"},       64'(rsp_tag),   64'(t));
    check_val({tag, "_stb_count"}, 64'(stb_cnt - s0), 64'(exp_stb));
    if (exp_stb == 1) begin
      check_val({tag, "_sh_shift"}, cap_shift, exp_shift);
      check_val({tag, "_sh_value"}, cap_value, exp_sv);
      check_val({tag, "_sh_dir"},   {62'd0, cap_left, cap_arith},
                {62'd0, op == 2'd0, op == 2'd2});
    end

    spurious_ack = late_ack;
    held = rsp_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "_hold_valid"},  64'(rsp_valid), 64'd1);
      check_val({tag, "_hold_result"}, rsp_result,     held);
      check_val({tag, "_hold_tagerr"}, {59'd0, rsp_tag, rsp_err}, {59'd0, t, exp_err});
      check_val({tag, "_hold_ready"},  64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_after_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_val({tag, "_after_req_ready"}, 64'(req_ready), 64'd1);
    spurious_ack = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_alu32 = 1'b0;
    req_tag   = '0;
    req_value = '0;
    req_shift = '0;
    rsp_ready = 1'b0;

    apply_reset("reset");

    do_op("lsh64",    2'd0, 1'b0, 64'h1,                   64'h43, 2, 0, 1'b0);
    do_op("arsh64",   2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'd4,  2, 0, 1'b0);
    do_op("arsh32",   2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'd36, 2, 0, 1'b0);
    do_op("rsh32",    2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd4,  2, 0, 1'b0);
    do_op("timeout",  2'd0, 1'b0, 64'h1234,                64'd1,  0, 3, 1'b1);
    do_op("illegal",  2'd3, 1'b0, 64'hDEAD,                64'd2,  2, 1, 1'b1);
    do_op("stall",    2'd1, 1'b0, 64'hF0F0_0000_0000_0000, 64'd8,  2, 10, 1'b0);
    do_op("ack_last", 2'd2, 1'b1, 64'h0000_0000_F000_0001, 64'd31, TMO, 0, 1'b0);
    do_op("ack_late", 2'd0, 1'b1, 64'h5,                   64'd1,  TMO + 1, 0, 1'b0);

    // Reset while waiting for an ack that never comes
    ack_delay = 0;
    wait_ready("rst_wait");
    send_req(2'd0, 1'b0, 4'h7, 64'h3, 64'd2);
    repeat (3) @(negedge clk);
    check_val("rst_wait_in_wait", 64'({rsp_valid, req_ready, sh_stb}), 64'd0);
    apply_reset("rst_wait");
    do_op("post_rst", 2'd0, 1'b0, 64'h1, 64'd5, 2, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      int d;
      op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      d  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
      do_op("rand", op, 1'($urandom), {$urandom, $urandom},
            ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 63)) : {$urandom, $urandom},
            d, $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
